// File: rtl/mult_rr_arbiter_pkg.sv
// Shared constants for the multiplier round-robin arbiter: FSM state
// encoding and datapath widths.
package mult_rr_arbiter_pkg;

  localparam int OPND_W = 8;
  localparam int PROD_W = 15;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

endpackage

// File: rtl/mult_rr_arbiter_rr_pick2.sv
// Two-way round-robin pick. When both requesters are active the one that
// did not win last time is chosen; otherwise the single active one wins.
// winner: 0 = requester 0, 1 = requester 1. any: at least one request.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic any
);

  assign any    = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mult_rr_arbiter.sv
// Shares one shift-add multiplier between two requesters. Round-robin grant,
// operand latch, one-cycle start, wait for a fresh done, capture product and
// sign, one-cycle response pulse to the owner.
// Optional ARB_TIMEOUT_EN: abort a WAIT that exceeds TIMEOUT cycles and
// answer with rsp_err=1 and a zero result.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch winner operands
// ISSUE | one-cycle m_start; arm stale-done filter and wait timer
// WAIT  | wait for m_done rising after having seen it low
// RESP  | one-cycle rsp_valid for the owner, then release grant
module mult_rr_arbiter
  import mult_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [OPND_W-1:0] a0,
  input  logic [OPND_W-1:0] b0,
  input  logic              req1,
  input  logic [OPND_W-1:0] a1,
  input  logic [OPND_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  output logic [PROD_W-1:0] rsp_product,
  output logic              rsp_sign,
  output logic              rsp_err,
  output logic              busy,
  output logic              m_start,
  output logic [OPND_W-1:0] m_multiplicand,
  output logic [OPND_W-1:0] m_multiplier,
  input  logic              m_done,
  input  logic [PROD_W-1:0] m_product,
  input  logic              m_sign
);

  if ((2 ** CNT_W) <= TIMEOUT) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT");
  end

  logic [1:0] state;
  logic       last;
  logic       seen_low;
  logic       pick_winner;
  logic       pick_any;
  logic       capture;
  logic       timeout_hit;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // A done only counts once it has been observed low in this transaction,
  // so a level left high by the previous operation is not taken as ours.
  assign capture = m_done & seen_low;

  assign m_start    = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign rsp_valid0 = (state == RESP) & gnt0;
  assign rsp_valid1 = (state == RESP) & gnt1;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Down-counter loaded at ISSUE; terminal count in WAIT without a capture aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == ISSUE)
      wait_cnt <= CNT_W'(TIMEOUT - 1);
    else if ((state == WAIT) && (wait_cnt != '0))
      wait_cnt <= wait_cnt - CNT_W'(1);
  end

  assign timeout_hit = (wait_cnt == '0) & ~capture;

  // Error flag accompanies each response: set on abort, cleared on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rsp_err <= 1'b0;
    else if ((state == WAIT) && capture)
      rsp_err <= 1'b0;
    else if ((state == WAIT) && timeout_hit)
      rsp_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // Arbitration FSM with grant, last-winner and operand latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last           <= 1'b1;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      m_multiplicand <= '0;
      m_multiplier   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt0           <= ~pick_winner;
            gnt1           <= pick_winner;
            last           <= pick_winner;
            m_multiplicand <= pick_winner ? a1 : a0;
            m_multiplier   <= pick_winner ? b1 : b0;
            state          <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (capture || timeout_hit)
            state <= RESP;
        end
        RESP: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stale-done filter: cleared at ISSUE, set once m_done is seen low in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      seen_low <= 1'b0;
    else if (state == ISSUE)
      seen_low <= 1'b0;
    else if ((state == WAIT) && !m_done)
      seen_low <= 1'b1;
  end

  // Result registers hold between responses for the display path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_product <= '0;
      rsp_sign    <= 1'b0;
    end else if (state == WAIT) begin
      if (capture) begin
        rsp_product <= m_product;
        rsp_sign    <= m_sign;
      end else if (timeout_hit) begin
        rsp_product <= '0;
        rsp_sign    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Self-checking bench for mult_rr_arbiter with a behavioural multiplier
// (configurable latency, stale-done and stuck-low modes) and a transaction
// level round-robin reference.
module tb_mult_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        gnt0, gnt1, rsp_valid0, rsp_valid1;
  logic [14:0] rsp_product;
  logic        rsp_sign, rsp_err, busy, m_start;
  logic [7:0]  m_multiplicand, m_multiplier;
  logic        m_done;
  logic [14:0] m_product;
  logic        m_sign;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mult_rr_arbiter #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_product(rsp_product), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
    .busy(busy), .m_start(m_start),
    .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier),
    .m_done(m_done), .m_product(m_product), .m_sign(m_sign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sprod(input logic [7:0] a, input logic [7:0] b);
    return int'($signed(a)) * int'($signed(b));
  endfunction

  function automatic logic [14:0] mag(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = sprod(a, b);
    if (p < 0) p = -p;
    return 15'(p);
  endfunction

  function automatic logic neg(input logic [7:0] a, input logic [7:0] b);
    return sprod(a, b) < 0;
  endfunction

  // Behavioural multiplier: done rises lat cycles after the start edge and
  // stays high until the next start.
  int         lat = 9;
  bit         stale_mode = 1'b0;
  bit         stuck_mode = 1'b0;
  int         m_cnt;
  bit         m_run, m_hold;
  logic [7:0] m_a, m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= 1'b0; m_product <= '0; m_sign <= 1'b0;
      m_run <= 1'b0; m_hold <= 1'b0; m_cnt <= 0;
    end else if (m_start) begin
      m_a    <= m_multiplicand;
      m_b    <= m_multiplier;
      m_cnt  <= lat - 1;
      m_run  <= !stuck_mode;
      m_hold <= stale_mode;
      if (!stale_mode) m_done <= 1'b0;
    end else if (m_run) begin
      if (m_hold) begin
        m_done <= 1'b0;
        m_hold <= 1'b0;
      end
      if (m_cnt == 0) begin
        m_done    <= 1'b1;
        m_product <= mag(m_a, m_b);
        m_sign    <= neg(m_a, m_b);
        m_run     <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Per-cycle exclusivity checks and response/grant counters.
  int rv0_n = 0, rv1_n = 0, gnt1_cyc = 0;
  always @(negedge clk) begin
    chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
    chk("rsp_exclusive", 32'(rsp_valid0 & rsp_valid1), 32'd0);
    if (rsp_valid0) rv0_n++;
    if (rsp_valid1) rv1_n++;
    if (gnt1) gnt1_cyc++;
  end

  int          tb_last = 1;
  logic [14:0] last_prod;

  function automatic int model_pick(input logic r0, input logic r1);
    int w;
    if (r0 && r1) w = 1 - tb_last;
    else          w = r1 ? 1 : 0;
    tb_last = w;
    return w;
  endfunction

  // Follows one transaction from grant to response. Call at a negedge in
  // IDLE or RESP; returns at the RESP negedge of this transaction.
  task automatic run_txn(input int who, input logic [7:0] ea, input logic [7:0] eb,
                         input int L, input bit exp_err);
    int c, k;
    logic [14:0] ep;
    logic es;
    ep = exp_err ? 15'd0 : mag(ea, eb);
    es = exp_err ? 1'b0 : neg(ea, eb);
    @(negedge clk);
    c = 0;
    while (!(who != 0 ? gnt1 : gnt0) && c < 300) begin @(negedge clk); c++; end
    chk("grant_seen",  32'(who != 0 ? gnt1 : gnt0), 32'd1);
    chk("grant_other", 32'(who != 0 ? gnt0 : gnt1), 32'd0);
    chk("issue_start", 32'(m_start), 32'd1);
    chk("latch_a", 32'(m_multiplicand), 32'(ea));
    chk("latch_b", 32'(m_multiplier), 32'(eb));
    k = 0;
    while (!(who != 0 ? rsp_valid1 : rsp_valid0) && k < 300) begin @(negedge clk); k++; end
    chk("rsp_latency", 32'(k), 32'(L + 2));
    chk("rsp_other", 32'(who != 0 ? rsp_valid0 : rsp_valid1), 32'd0);
    chk("rsp_gnt_held", 32'(who != 0 ? gnt1 : gnt0), 32'd1);
    chk("rsp_product", 32'(rsp_product), 32'(ep));
    chk("rsp_sign", 32'(rsp_sign), 32'(es));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    last_prod = ep;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, r0b, r1b, g1b, c;
    logic [1:0] pat;

    rst = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    #1;
    chk("reset_ctrl", 32'({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_sign, rsp_err, busy, m_start}), 32'd0);
    chk("reset_data", 32'({rsp_product, m_multiplicand, m_multiplier}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single requester 0: -3 * 5, 9-cycle multiplier.
    r0b = rv0_n; g1b = gnt1_cyc;
    req0 = 1; a0 = 8'hFD; b0 = 8'h05; lat = 9;
    w = model_pick(req0, req1);
    run_txn(w, a0, b0, 9, 0);
    chk("t1_product_15", 32'(rsp_product), 32'd15);
    req0 = 0;
    repeat (3) @(negedge clk);
    chk("t1_one_rsp0", 32'(rv0_n - r0b), 32'd1);
    chk("t1_no_gnt1", 32'(gnt1_cyc - g1b), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_hold_product", 32'(rsp_product), 32'(last_prod));

    // Both held continuously after reset: 0,1,0,1.
    rst = 1'b1; @(negedge clk); rst = 1'b0; tb_last = 1;
    req0 = 1; req1 = 1;
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      lat = $urandom_range(2, 8);
      w = model_pick(req0, req1);
      chk("alt_order", 32'(w), 32'(i % 2));
      run_txn(w, w != 0 ? a1 : a0, w != 0 ? b1 : b0, lat, 0);
      if (w != 0) begin a1 = 8'($urandom); b1 = 8'($urandom); end
      else        begin a0 = 8'($urandom); b0 = 8'($urandom); end
    end
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);

    // Stale done left high from the previous op, lowered one cycle after start.
    stale_mode = 1; lat = 5;
    req0 = 1; a0 = 8'h11; b0 = 8'hF3;
    w = model_pick(req0, req1);
    run_txn(w, a0, b0, 5, 0);
    req0 = 0; stale_mode = 0;
    repeat (2) @(negedge clk);

    // Operand change after grant is ignored; req dropped mid-transaction.
    req1 = 1; a1 = 8'h02; b1 = 8'h03; lat = 4;
    w = model_pick(req0, req1);
    fork
      run_txn(w, 8'h02, 8'h03, 4, 0);
      begin
        for (int i = 0; i < 300 && !gnt1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        a1 = 8'h7F;
        req1 = 0;
      end
    join
    chk("t4_latched_a", 32'(m_multiplicand), 32'h02);
    chk("t4_product_6", 32'(rsp_product), 32'd6);
    repeat (2) @(negedge clk);

    // Reset in the middle of WAIT.
    req0 = 1; a0 = 8'h81; b0 = 8'h7F; lat = 20;
    c = 0;
    while (!gnt0 && c < 300) begin @(negedge clk); c++; end
    repeat (5) @(negedge clk);
    chk("t5_in_wait", 32'(busy), 32'd1);
    r0b = rv0_n; r1b = rv1_n;
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", 32'({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_sign, rsp_err, busy, m_start}), 32'd0);
    chk("midrst_data", 32'({rsp_product, m_multiplicand, m_multiplier}), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_no_rsp", 32'(rv0_n - r0b), 32'd0);
    rst = 1'b0; tb_last = 1;
    req1 = 1; a0 = 8'h9C; b0 = 8'h0B; a1 = 8'h07; b1 = 8'hF9; lat = 6;
    w = model_pick(req0, req1);
    chk("t5_tie_to_0", 32'(w), 32'd0);
    run_txn(w, a0, b0, 6, 0);
    req0 = 0;
    w = model_pick(req0, req1);
    run_txn(w, a1, b1, 6, 0);
    req1 = 0;
    repeat (3) @(negedge clk);
    chk("t5_rsp0_count", 32'(rv0_n - r0b), 32'd1);
    chk("t5_rsp1_count", 32'(rv1_n - r1b), 32'd1);

    // Multiplier done stuck low.
    stuck_mode = 1;
    req1 = 1; a1 = 8'h33; b1 = 8'h44;
    w = model_pick(req0, req1);
`ifdef ARB_TIMEOUT_EN
    run_txn(w, a1, b1, 63, 1);
    req1 = 0;
`else
    r1b = rv1_n;
    repeat (100) @(negedge clk);
    chk("stuck_busy", 32'(busy), 32'd1);
    chk("stuck_gnt1", 32'(gnt1), 32'd1);
    chk("stuck_no_rsp", 32'(rv1_n - r1b), 32'd0);
    req1 = 0;
    rst = 1'b1; @(negedge clk); rst = 1'b0; tb_last = 1;
`endif
    stuck_mode = 0;
    repeat (2) @(negedge clk);

    // Randomized request patterns, operands and multiplier latency.
    for (int i = 0; i < 30; i++) begin
      pat = 2'($urandom_range(1, 3));
      req0 = pat[0]; req1 = pat[1];
      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      lat = $urandom_range(1, 12);
      w = model_pick(req0, req1);
      run_txn(w, w != 0 ? a1 : a0, w != 0 ? b1 : b0, lat, 0);
    end
    req0 = 0; req1 = 0;
    repeat (4) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);
    chk("final_hold_product", 32'(rsp_product), 32'(last_prod));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mult_rr_arbiter.md
Name: mult_rr_arbiter

Overview:
Shares the single 8x8 signed shift-add multiplier between two requesters, e.g. the button/switch path and a second operand source. It arbitrates round-robin and latches the winner's operands, then issues a one-cycle start to the multiplier. It waits for the multiplier's done, captures the 15-bit magnitude product and sign, and returns them to the owning requester with a one-cycle valid. It sits between the requesters and the multiplier; the product/sign outputs feed bin2bcd and the digit/sign selection logic.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT before abort (only with ARB_TIMEOUT_EN)
CNT_W, 7, width of wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req0  in  1  requester 0 request, level, held until rsp_valid0
a0  in  8  requester 0 multiplicand, two's complement
b0  in  8  requester 0 multiplier, two's complement
req1  in  1  requester 1 request, level
a1  in  8  requester 1 multiplicand
b1  in  8  requester 1 multiplier
gnt0  out  1  requester 0 owns the multiplier
gnt1  out  1  requester 1 owns the multiplier
rsp_valid0  out  1  one-cycle pulse, result for requester 0
rsp_valid1  out  1  one-cycle pulse, result for requester 1
rsp_product  out  15  captured magnitude product, stable until next capture
rsp_sign  out  1  captured sign (1 = negative)
rsp_err  out  1  result aborted by timeout; valid with rsp_valid*
busy  out  1  state != IDLE
m_start  out  1  one-cycle start pulse to multiplier
m_multiplicand  out  8  latched operand
m_multiplier  out  8  latched operand
m_done  in  1  multiplier done, level; may remain high until the next start
m_product  in  15  multiplier magnitude product
m_sign  in  1  multiplier sign

Behaviour:
- Reset (async, any state): state=IDLE, last=1 (requester 0 wins the first tie). All outputs 0, including rsp_product, rsp_sign, m_multiplicand and m_multiplier. Reset mid-WAIT drops the transaction; no rsp_valid is issued.
- States:
  - IDLE: if no req, stay. If exactly one req, grant it. If both, grant the one != last. On grant: latch a/b into m_multiplicand/m_multiplier, set gnt, set last=winner, go to ISSUE.
  - ISSUE (1 cycle): m_start=1, clear seen_low and the wait counter, go to WAIT.
  - WAIT: set seen_low when m_done==0. Capture only when m_done==1 and seen_low is already set. This ignores a stale done left high from the previous operation. On capture: rsp_product<=m_product, rsp_sign<=m_sign, rsp_err<=0, go to RESP.
  - RESP (1 cycle): rsp_validN=1 for the owner, then gnt cleared and go to IDLE.
- gntN is high from the grant edge through the RESP cycle inclusive; at most one gnt is high at any time.
- Latency: minimum req-to-rsp_valid is 1 (grant) + 1 (ISSUE) + multiplier latency + 1 (RESP).
- Back-to-back requests:
  - A req still high in the cycle after RESP is a new request.
  - With both requesting continuously, grants alternate 0,1,0,1.
- Operand changes on a/b after the grant are ignored for that transaction.
- A req dropped during a transaction does not abort it; the response is still pulsed.
- rsp_product and rsp_sign hold their value between responses (the display reads them while idle).

Optional Feature:
ARB_TIMEOUT_EN
- Defined: WAIT counts cycles. At count==TIMEOUT-1 without capture, go to RESP with rsp_err=1, rsp_product=0 and rsp_sign=0.
- Undefined: no counter; WAIT waits indefinitely, and rsp_err is tied to 0.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3), operand width 8, product width 15.
- One sub-module is natural: rr_pick2 (combinational two-way round-robin pick from req0, req1, last; outputs winner and any).
- The FSM and datapath latches stay in mult_rr_arbiter.

Test Plan:
- req0 only, a0=8'hFD (-3), b0=8'h05, model multiplier 9-cycle latency -> gnt0 then m_start pulse, rsp_valid0 once, rsp_product=15, rsp_sign=1, gnt1 never high.
- req0 and req1 together after reset, both held -> first grant to 0, then 1, then 0; rsp_valid0 and rsp_valid1 alternate, never in the same cycle.
- m_done held high from the prior op at ISSUE and lowered 1 cycle later -> no capture until the next rising done; captured value equals the new product.
- a1 changes from 8'h02 to 8'h7F two cycles after gnt1 -> m_multiplicand stays 8'h02 and the product reflects 2.
- rst asserted mid-WAIT -> all outputs 0 immediately, no rsp_valid; a later req0 is served normally and wins the tie.
- With ARB_TIMEOUT_EN and TIMEOUT=64, m_done stuck low -> rsp_valid for the owner 64 cycles after entering WAIT, with rsp_err=1 and rsp_product=0; without the macro, busy remains high.
